// File: rtl/adpll_gain_scheduler.sv
// Gain scheduler for an all-digital PLL. It applies acquisition gains until the phase
// error stays in band long enough, then switches to tracking gains and watches for loss of lock.
module adpll_gain_scheduler #(
    parameter int PDET_WIDTH    = 8,
    parameter int KP_WIDTH      = 5,
    parameter int KI_WIDTH      = 9,
    parameter int LOCK_THRESH   = 4,
    parameter int LOCK_COUNT    = 64,
    parameter int UNLOCK_THRESH = 12,
    parameter int UNLOCK_COUNT  = 8,
    parameter int TIMEOUT_EDGES = 4096
) (
    input  logic                         fpga_clk_i,
    input  logic                         rst_pbn_i,
    input  logic                         start_i,
    input  logic                         err_valid_i,
    input  logic signed [PDET_WIDTH-1:0] error_i,
    input  logic        [KP_WIDTH-1:0]   kp_acq_i,
    input  logic        [KI_WIDTH-1:0]   ki_acq_i,
    input  logic        [KP_WIDTH-1:0]   kp_trk_i,
    input  logic        [KI_WIDTH-1:0]   ki_trk_i,
    output logic                         enable_o,
    output logic        [KP_WIDTH-1:0]   kp_o,
    output logic        [KI_WIDTH-1:0]   ki_o,
    output logic                         locked_o,
    output logic                         lost_o,
    output logic                         fault_o,
    output logic        [1:0]            state_o
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_TRACK   = 2'd2;
    localparam logic [1:0] ST_FAULT   = 2'd3;

    localparam int IB_W = $clog2(LOCK_COUNT + 1);
    localparam int OB_W = $clog2(UNLOCK_COUNT + 1);
    localparam int TO_W = $clog2(TIMEOUT_EDGES + 1);
    localparam logic [IB_W-1:0] IB_MAX = IB_W'(LOCK_COUNT);
    localparam logic [OB_W-1:0] OB_MAX = OB_W'(UNLOCK_COUNT);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_EDGES);

    localparam logic [PDET_WIDTH-1:0] ERR_MIN   = {1'b1, {(PDET_WIDTH-1){1'b0}}};
    localparam logic [PDET_WIDTH-1:0] ERR_MAX   = {1'b0, {(PDET_WIDTH-1){1'b1}}};
    localparam logic [PDET_WIDTH-1:0] LOCK_TH   = PDET_WIDTH'(LOCK_THRESH);
    localparam logic [PDET_WIDTH-1:0] UNLOCK_TH = PDET_WIDTH'(UNLOCK_THRESH);

    logic [1:0]            r_state;
    logic [KP_WIDTH-1:0]   r_kp;
    logic [KI_WIDTH-1:0]   r_ki;
    logic                  r_enable, r_locked, r_lost, r_fault;
    logic [IB_W-1:0]       r_ib_cnt;
    logic [OB_W-1:0]       r_ob_cnt;
    logic [TO_W-1:0]       r_to_cnt;

    logic [1:0]            w_state_next;
    logic [KP_WIDTH-1:0]   w_kp_next;
    logic [KI_WIDTH-1:0]   w_ki_next;
    logic                  w_enable_next, w_locked_next, w_lost_next, w_fault_next;
    logic [IB_W-1:0]       w_ib_next, w_ib_inc;
    logic [OB_W-1:0]       w_ob_next, w_ob_inc;
    logic [TO_W-1:0]       w_to_next, w_to_inc;
    logic [PDET_WIDTH-1:0] w_mag;
    logic                  w_inband, w_outband;

    // The most negative code has no positive twin, so its magnitude clips to the largest positive code.
    assign w_mag = (error_i == ERR_MIN) ? ERR_MAX
                 : (error_i[PDET_WIDTH-1] ? -error_i : error_i);
    assign w_inband  = err_valid_i && (w_mag <= LOCK_TH);
    assign w_outband = err_valid_i && (w_mag > UNLOCK_TH);

    assign w_ib_inc = (r_ib_cnt == IB_MAX) ? IB_MAX : r_ib_cnt + IB_W'(1);
    assign w_ob_inc = (r_ob_cnt == OB_MAX) ? OB_MAX : r_ob_cnt + OB_W'(1);
    assign w_to_inc = (r_to_cnt == TO_MAX) ? TO_MAX : r_to_cnt + TO_W'(1);

    always_comb begin
        w_state_next  = r_state;
        w_kp_next     = r_kp;
        w_ki_next     = r_ki;
        w_enable_next = r_enable;
        w_locked_next = r_locked;
        w_lost_next   = 1'b0;
        w_fault_next  = r_fault;
        w_ib_next     = r_ib_cnt;
        w_ob_next     = r_ob_cnt;
        w_to_next     = r_to_cnt;
        if (!start_i) begin
            w_state_next  = ST_IDLE;
            w_enable_next = 1'b0;
            w_locked_next = 1'b0;
            w_fault_next  = 1'b0;
            w_ib_next     = '0;
            w_ob_next     = '0;
            w_to_next     = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next  = ST_ACQUIRE;
                    w_kp_next     = kp_acq_i;
                    w_ki_next     = ki_acq_i;
                    w_enable_next = 1'b1;
                    w_locked_next = 1'b0;
                    w_fault_next  = 1'b0;
                    w_ib_next     = '0;
                    w_to_next     = '0;
                end
                ST_ACQUIRE: begin
                    if (err_valid_i) begin
                        w_ib_next = w_inband ? w_ib_inc : '0;
                        w_to_next = w_to_inc;
                        // Lock is tested first so it wins a tie with the timeout.
                        if (w_ib_next == IB_MAX) begin
                            w_state_next  = ST_TRACK;
                            w_kp_next     = kp_trk_i;
                            w_ki_next     = ki_trk_i;
                            w_locked_next = 1'b1;
                            w_ob_next     = '0;
                        end else if (w_to_next == TO_MAX) begin
                            w_state_next  = ST_FAULT;
                            w_enable_next = 1'b0;
                            w_fault_next  = 1'b1;
                        end
                    end
                end
                ST_TRACK: begin
                    if (err_valid_i) begin
                        w_ob_next = w_outband ? w_ob_inc : '0;
                        if (w_ob_next == OB_MAX) begin
                            w_state_next  = ST_ACQUIRE;
                            w_kp_next     = kp_acq_i;
                            w_ki_next     = ki_acq_i;
                            w_locked_next = 1'b0;
                            w_lost_next   = 1'b1;
                            w_ib_next     = '0;
                            w_to_next     = '0;
                        end
                    end
                end
                default: begin
                    w_enable_next = 1'b0;
                    w_locked_next = 1'b0;
                    w_fault_next  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
        if (!rst_pbn_i) begin
            r_state  <= ST_IDLE;
            r_kp     <= '0;
            r_ki     <= '0;
            r_enable <= 1'b0;
            r_locked <= 1'b0;
            r_lost   <= 1'b0;
            r_fault  <= 1'b0;
            r_ib_cnt <= '0;
            r_ob_cnt <= '0;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_kp     <= w_kp_next;
            r_ki     <= w_ki_next;
            r_enable <= w_enable_next;
            r_locked <= w_locked_next;
            r_lost   <= w_lost_next;
            r_fault  <= w_fault_next;
            r_ib_cnt <= w_ib_next;
            r_ob_cnt <= w_ob_next;
            r_to_cnt <= w_to_next;
        end
    end

    assign state_o  = r_state;
    assign kp_o     = r_kp;
    assign ki_o     = r_ki;
    assign enable_o = r_enable;
    assign locked_o = r_locked;
    assign lost_o   = r_lost;
    assign fault_o  = r_fault;
endmodule

// File: tb/tb_adpll_gain_scheduler.sv
// Directed bench for adpll_gain_scheduler: a default instance plus one with short
// lock/timeout limits so the timeout and lock-versus-timeout tie can be reached quickly.
module tb_adpll_gain_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, start, valid;
    logic signed [7:0] err;
    logic [4:0]        kp_acq, kp_trk;
    logic [8:0]        ki_acq, ki_trk;

    logic       m_en, m_locked, m_lost, m_fault;
    logic [4:0] m_kp;
    logic [8:0] m_ki;
    logic [1:0] m_state;
    logic       t_en, t_locked, t_lost, t_fault;
    logic [4:0] t_kp;
    logic [8:0] t_ki;
    logic [1:0] t_state;

    adpll_gain_scheduler dut (
        .fpga_clk_i(clk), .rst_pbn_i(rst_n), .start_i(start), .err_valid_i(valid),
        .error_i(err), .kp_acq_i(kp_acq), .ki_acq_i(ki_acq), .kp_trk_i(kp_trk),
        .ki_trk_i(ki_trk), .enable_o(m_en), .kp_o(m_kp), .ki_o(m_ki),
        .locked_o(m_locked), .lost_o(m_lost), .fault_o(m_fault), .state_o(m_state)
    );

    adpll_gain_scheduler #(.LOCK_COUNT(16), .TIMEOUT_EDGES(16)) dut_to (
        .fpga_clk_i(clk), .rst_pbn_i(rst_n), .start_i(start), .err_valid_i(valid),
        .error_i(err), .kp_acq_i(kp_acq), .ki_acq_i(ki_acq), .kp_trk_i(kp_trk),
        .ki_trk_i(ki_trk), .enable_o(t_en), .kp_o(t_kp), .ki_o(t_ki),
        .locked_o(t_locked), .lost_o(t_lost), .fault_o(t_fault), .state_o(t_state)
    );

    // Packed view: {state[1:0], kp[4:0], ki[8:0], locked, lost, enable, fault}
    logic [19:0] m_vec, t_vec;
    assign m_vec = {m_state, m_kp, m_ki, m_locked, m_lost, m_en, m_fault};
    assign t_vec = {t_state, t_kp, t_ki, t_locked, t_lost, t_en, t_fault};

    localparam logic [19:0] M_ALL    = 20'hFFFFF;
    localparam logic [19:0] M_NOGAIN = 20'hC000F;

    int checks = 0;
    int errors = 0;

    function automatic logic [19:0] pk(input int st, input int kp, input int ki,
                                       input bit lk, input bit ls, input bit en, input bit ft);
        return {st[1:0], kp[4:0], ki[8:0], lk, ls, en, ft};
    endfunction

    task automatic chk(input string name, input logic [19:0] act,
                       input logic [19:0] exp, input logic [19:0] mask);
        checks++;
        if ((act & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s got=%05h expected=%05h (mask %05h)", name, act, exp, mask);
        end else begin
            $display("check %-14s ok  vec=%05h", name, act);
        end
    endtask

    task automatic step(input bit s, input bit v, input int e);
        start = s;
        valid = v;
        err   = 8'(e);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          s;
        bit          v;
        int          e;
        logic [19:0] exp;
    } vec_t;

    vec_t        tbl[5];
    logic [19:0] IDLE0, ACQ, TRK, LOST, FLT;

    initial begin
        IDLE0 = pk(0, 0, 0, 0, 0, 0, 0);
        ACQ   = pk(1, 16, 8, 0, 0, 1, 0);
        TRK   = pk(2, 9, 1, 1, 0, 1, 0);
        LOST  = pk(1, 16, 8, 0, 1, 1, 0);
        FLT   = pk(3, 16, 8, 0, 0, 0, 1);
        tbl[0] = '{s: 1'b0, v: 1'b0, e: 0,    exp: IDLE0};
        tbl[1] = '{s: 1'b0, v: 1'b1, e: 3,    exp: IDLE0};
        tbl[2] = '{s: 1'b1, v: 1'b0, e: 0,    exp: ACQ};
        tbl[3] = '{s: 1'b1, v: 1'b0, e: 0,    exp: ACQ};
        tbl[4] = '{s: 1'b1, v: 1'b1, e: -128, exp: ACQ};

        rst_n = 1'b0; start = 1'b0; valid = 1'b0; err = '0;
        kp_acq = 5'd16; ki_acq = 9'd8; kp_trk = 5'd9; ki_trk = 9'd1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", m_vec, IDLE0, M_ALL);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step(tbl[i].s, tbl[i].v, tbl[i].e);
            chk($sformatf("tbl%0d", i), m_vec, tbl[i].exp, M_ALL);
        end

        // Lock after exactly 64 in-band samples
        for (int i = 0; i < 64; i++) begin
            step(1, 1, 3);
            chk($sformatf("lock%0d", i + 1), m_vec, (i == 63) ? TRK : ACQ, M_ALL);
        end

        // Tracking gain inputs move while locked; outputs must hold
        kp_trk = 5'd3; ki_trk = 9'd7;
        step(1, 0, 0);
        chk("gain_hold0", m_vec, TRK, M_ALL);
        step(1, 1, 0);
        chk("gain_hold1", m_vec, TRK, M_ALL);

        // |error| = 12 is not out-of-band
        for (int i = 0; i < 8; i++) step(1, 1, -12);
        chk("ob_boundary", m_vec, TRK, M_ALL);
        kp_trk = 5'd9; ki_trk = 9'd1;

        // Loss of lock
        for (int i = 0; i < 7; i++) begin
            step(1, 1, -20);
            chk($sformatf("ob20_%0d", i + 1), m_vec, TRK, M_ALL);
        end
        step(1, 1, 0);
        chk("ob_clear", m_vec, TRK, M_ALL);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, -128);
            chk($sformatf("ob128_%0d", i + 1), m_vec, (i == 7) ? LOST : TRK, M_ALL);
        end
        step(1, 0, 0);
        chk("lost_pulse_end", m_vec, ACQ, M_ALL);

        // In-band counter cleared by one out-of-band-for-lock sample; idle cycle holds it
        for (int i = 0; i < 63; i++) step(1, 1, -4);
        chk("ib63", m_vec, ACQ, M_ALL);
        step(1, 1, 5);
        chk("ib_clear", m_vec, ACQ, M_ALL);
        for (int i = 0; i < 64; i++) begin
            if (i == 10) begin
                step(1, 0, 0);
                chk("ib_gap", m_vec, ACQ, M_ALL);
            end
            step(1, 1, 0);
            chk($sformatf("relock%0d", i + 65), m_vec, (i == 63) ? TRK : ACQ, M_ALL);
        end

        // start_i low in TRACK while a loss would complete: IDLE, no lost pulse
        for (int i = 0; i < 7; i++) step(1, 1, -128);
        chk("pre_abort", m_vec, TRK, M_ALL);
        step(0, 1, -128);
        chk("abort_start", m_vec, IDLE0, M_NOGAIN);
        step(1, 0, 0);
        chk("restart", m_vec, ACQ, M_ALL);

        // Asynchronous reset in TRACK
        for (int i = 0; i < 64; i++) step(1, 1, 0);
        chk("track_again", m_vec, TRK, M_ALL);
        for (int i = 0; i < 7; i++) step(1, 1, -128);
        #2;
        rst_n = 1'b0; valid = 1'b1; err = -8'sd128;
        #1;
        chk("rst_async", m_vec, IDLE0, M_ALL);
        @(posedge clk);
        #1;
        chk("rst_hold", m_vec, IDLE0, M_ALL);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release", m_vec, ACQ, M_ALL);

        // Acquisition timeout on the short-limit instance
        step(0, 0, 0);
        step(1, 0, 0);
        chk("to_entry", t_vec, ACQ, M_ALL);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 50);
            chk($sformatf("to%0d", i + 1), t_vec, (i == 15) ? FLT : ACQ, M_ALL);
        end
        chk("main_no_to", m_vec, ACQ, M_ALL);
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0);
            chk($sformatf("fault_hold%0d", i), t_vec, FLT, M_ALL);
        end
        step(0, 0, 0);
        chk("fault_exit", t_vec, IDLE0, M_NOGAIN);

        // Lock and timeout complete on the same sample: lock wins
        step(1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 1);
            chk($sformatf("tie%0d", i + 1), t_vec, (i == 15) ? TRK : ACQ, M_ALL);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adpll_gain_scheduler.md
ADPLL_GAIN_SCHEDULER -- requirements
Module: adpll_gain_scheduler

Interface
REQ-001 The module SHALL have these parameters: PDET_WIDTH, 8, signed phase-error width; KP_WIDTH, 5, kp word width; KI_WIDTH, 9, ki word width; LOCK_THRESH, 4, in-band limit on |error| in fpga_clk_i cycles; LOCK_COUNT, 64, consecutive in-band samples needed to declare lock; UNLOCK_THRESH, 12, out-of-band limit on |error|; UNLOCK_COUNT, 8, consecutive out-of-band samples needed to declare loss of lock; TIMEOUT_EDGES, 4096, maximum samples allowed in ACQUIRE.
REQ-002 The module SHALL have these ports:
- fpga_clk_i, in, 1, single system clock.
- rst_pbn_i, in, 1, asynchronous active-low reset.
- start_i, in, 1, level; high runs the loop, low forces IDLE.
- err_valid_i, in, 1, one-cycle strobe; error_i is valid in this cycle.
- error_i, in, PDET_WIDTH, signed phase-detector output.
- kp_acq_i / ki_acq_i, in, KP_WIDTH / KI_WIDTH, acquisition gains.
- kp_trk_i / ki_trk_i, in, KP_WIDTH / KI_WIDTH, tracking gains.
- enable_o, out, 1, ADPLL enable.
- kp_o / ki_o, out, KP_WIDTH / KI_WIDTH, gains applied to the ADPLL.
- locked_o, out, 1, lock indication.
- lost_o, out, 1, one-cycle pulse on loss of lock.
- fault_o, out, 1, acquisition timeout flag.
- state_o, out, 2, encoded state.

Function
REQ-003 The module SHALL implement the states IDLE=0, ACQUIRE=1, TRACK=2 and FAULT=3, and SHALL drive the current encoding on state_o.
REQ-004 All outputs SHALL be registered, and SHALL update on the same fpga_clk_i edge as the state register.
REQ-005 The module SHALL compute mag = |error_i|, saturating -2^(PDET_WIDTH-1) to 2^(PDET_WIDTH-1)-1.
REQ-006 A sample SHALL be in-band when err_valid_i is high and mag <= LOCK_THRESH.
REQ-007 A sample SHALL be out-of-band when err_valid_i is high and mag > UNLOCK_THRESH.
REQ-008 Cycles with err_valid_i low SHALL leave all counters unchanged.
REQ-009 In IDLE, the module SHALL drive enable_o=0, locked_o=0 and fault_o=0; if start_i=1, the next state SHALL be ACQUIRE.
REQ-010 On entry to ACQUIRE, the module SHALL latch kp_acq_i and ki_acq_i into kp_o and ki_o, drive enable_o=1, and clear the in-band counter and the timeout counter.
REQ-011 In ACQUIRE, an in-band sample SHALL increment the in-band counter, and any other valid sample SHALL clear it.
REQ-012 In ACQUIRE, every valid sample SHALL increment the timeout counter.
REQ-013 In ACQUIRE, the sample that brings the in-band counter to LOCK_COUNT SHALL move the state to TRACK on the next edge.
REQ-014 In ACQUIRE, if lock and timeout complete on the same sample, lock SHALL win.
REQ-015 In ACQUIRE, the sample that brings the timeout counter to TIMEOUT_EDGES without lock SHALL move the state to FAULT.
REQ-016 On entry to TRACK, the module SHALL latch kp_trk_i and ki_trk_i into kp_o and ki_o, set locked_o=1, and clear the out-of-band counter.
REQ-017 In TRACK, an out-of-band sample SHALL increment the out-of-band counter, and any other valid sample SHALL clear it.
REQ-018 In TRACK, reaching UNLOCK_COUNT SHALL move the state to ACQUIRE, clear locked_o, pulse lost_o for exactly one cycle, and re-latch the acquisition gains.
REQ-019 In FAULT, the module SHALL drive enable_o=0, fault_o=1 and locked_o=0, and SHALL hold the state until start_i=0.
REQ-020 start_i=0 in any state SHALL force IDLE on the next edge with highest priority, clearing all counters and locked_o and suppressing lost_o.
REQ-021 Changes on the gain inputs SHALL NOT affect kp_o or ki_o except on entry to ACQUIRE or TRACK.
REQ-022 Counters SHALL saturate at their terminal values and SHALL never wrap.

Reset
REQ-023 When rst_pbn_i=0, the module SHALL immediately force state IDLE, enable_o=0, kp_o=0, ki_o=0, locked_o=0, lost_o=0, fault_o=0 and all counters to 0.
REQ-024 The release of rst_pbn_i SHALL take effect on the next fpga_clk_i edge, and the module SHALL NOT require an in-band sample in order to leave reset.
REQ-025 Assertion of reset in any state SHALL abort the current operation with no lost_o pulse.

Verification
REQ-026 Lock scenario: start_i=1, kp_acq=16, ki_acq=8, kp_trk=9, ki_trk=1, then 64 valid samples with error=+3 -> state_o=1 with kp_o=16 until the 64th sample; on the next edge state_o=2, kp_o=9, ki_o=1, locked_o=1.
REQ-027 Counter-reset scenario: 63 samples with error=-4, then one sample with error=+5, then 64 samples with error=0 -> lock is declared only after sample 128.
REQ-028 Loss-of-lock scenario: in TRACK, 7 samples with error=-20, then one with error=0, then 8 with error=-128 -> no loss after the first 7; after the 8th -128 sample, lost_o is high for exactly 1 cycle, state_o=1 and kp_o=16.
REQ-029 Timeout scenario: TIMEOUT_EDGES=16 with 16 samples of error=50 -> state_o=3, fault_o=1, enable_o=0; then start_i=0 -> state_o=0 on the next edge.
REQ-030 Abort scenario: reset or start_i=0 asserted in TRACK -> all outputs return to IDLE values and lost_o stays low; kp_trk_i changed while in TRACK -> kp_o stays unchanged.
